fir_regbus_arbiter: RTL and testbench
=====================================

Name: fir_regbus_arbiter

Overview:
- Single-port arbiter for the 64x16 coefficient/config memory in the FIR clock domain.
- Shares that memory between two requesters:
  - Host: CDC-side register writes and readbacks, driven from the CDC_A / CDC_data / CDC_wr path.
  - Engine: read-only coefficient fetch by the FIR datapath.
- Sequences every access, protects a read-only region from host writes and returns read data to the requester that issued the read.

Parameters:
- AW, 6: address width (memory depth 2**AW).
- DW, 16: data width.
- RO_BASE, 48: host writes to addr >= RO_BASE are rejected; reads are allowed.
- HOST_PRIO, 0: 0 = round-robin; 1 = host wins every conflict.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- h_req  in  1  host request; held, with h_wr/h_addr/h_wdata stable, until h_gnt.
- h_wr  in  1  1 = write, 0 = read.
- h_addr  in  AW  host address.
- h_wdata  in  DW  host write data.
- h_gnt  out  1  one-cycle grant pulse.
- h_rvalid  out  1  one-cycle pulse; h_rdata valid.
- h_rdata  out  DW  host read data.
- h_err  out  1  one-cycle pulse: write to the read-only region was dropped.
- e_req  in  1  engine read request; held, with e_addr stable, until e_gnt.
- e_addr  in  AW  engine address.
- e_gnt  out  1  one-cycle grant pulse.
- e_rvalid  out  1  one-cycle pulse; e_rdata valid.
- e_rdata  out  DW  engine read data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  memory write enable (only with mem_en).
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after a mem_en read.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer = host (engine wins the first conflict).
  - Read-return pipeline flushed.
  - A read in flight at reset never produces rvalid.
- Arbitration (evaluated each cycle):
  - A requester is eligible if its req=1 and its gnt is not high this cycle. This blocks a double grant while the requester updates its request.
  - Only one eligible: it wins.
  - Both eligible:
    - HOST_PRIO=1: host wins.
    - Otherwise the requester not granted most recently wins.
  - The pointer updates on every grant.
- Command stage (registered):
  - The cycle after a win, gnt pulses together with mem_en=1, mem_addr and mem_wdata from the winner. mem_wr = h_wr for host, 0 for engine.
  - The memory bus carries at most one command per cycle.
  - Sustained throughput is one access per cycle with both requesters active, and one per 2 cycles for a single requester.
- Read-only protection:
  - A host write with h_addr >= RO_BASE is still granted (h_gnt pulses).
  - mem_en=0 and mem_wr=0 for that command; h_err pulses in the same cycle as h_gnt.
  - The memory is not modified and the round-robin pointer still advances.
  - Host write to RO_BASE-1 is accepted normally.
- Read return:
  - An owner-tag pipeline follows each read command.
  - mem_rdata is captured the cycle after the command. The matching rvalid/rdata pulses the cycle after that, i.e. 2 cycles after gnt (3 cycles after req first seen when idle).
  - rdata holds its last value when rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating requesters return in grant order with no loss.
- Simultaneous events:
  - A new command may issue in the same cycle a previous read returns.
  - h_err and h_rvalid may pulse in the same cycle (err for the new command, rvalid for an older read).
- Addresses wrap naturally within AW bits. No other range checks.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles with h_req=e_req=1 -> all outputs 0; first grant 1 cycle after rst falls goes to engine.
- Host write then read: write addr 5 data 0xABCD, then read addr 5 -> mem_en/mem_wr=1 with addr 5 one cycle after req; h_rvalid pulses 2 cycles after the read grant with h_rdata=0xABCD; h_err=0.
- Contention round-robin: host and engine request continuously (host reads addr 1/10, engine reads addr 32/63) -> grants alternate host/engine every cycle; each rvalid routed to the correct requester with the matching data (0x1111, 0x1234, 0xDEAD, 0xBEEF preloaded).
- HOST_PRIO=1: same stimulus as contention -> host granted on every eligible cycle; engine granted only in host's post-grant blocked cycles.
- Read-only guard: host write addr 48 data 0xBEEF -> h_gnt and h_err pulse, mem_en=0, memory at 48 unchanged. Write addr 47 -> accepted, h_err=0.
- Reset mid-read: assert rst in the cycle after an engine read grant -> e_rvalid never pulses; all outputs 0 next cycle.

Source files
------------

// File: rtl/fir_regbus_arbiter.sv
// Single-port arbiter sharing the FIR coefficient/config memory between host
// register accesses and engine coefficient fetches, with a host write-protected top region.
module fir_regbus_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter int RO_BASE   = 48,
  parameter int HOST_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h_req,
  input  logic          h_wr,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          h_err,
  input  logic          e_req,
  input  logic [AW-1:0] e_addr,
  output logic          e_gnt,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] RO_LIM = RO_BASE[AW:0];

  logic h_elig;
  logic e_elig;
  logic h_win;
  logic e_win;
  logic h_ro;
  logic last_host;
  logic rd_pend;
  logic rd_host;

  // A requester whose grant is pulsing this cycle is still changing its request.
  assign h_elig = h_req & ~h_gnt;
  assign e_elig = e_req & ~e_gnt;
  assign h_ro   = h_wr & ({1'b0, h_addr} >= RO_LIM);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    h_win = 1'b0;
    e_win = 1'b0;
    if (h_elig && e_elig) begin
      if (HOST_PRIO != 0 || !last_host) h_win = 1'b1;
      else                              e_win = 1'b1;
    end else begin
      h_win = h_elig;
      e_win = e_elig;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_gnt     <= 1'b0;
      e_gnt     <= 1'b0;
      h_err     <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_host <= 1'b1;
    end else begin
      h_gnt  <= h_win;
      e_gnt  <= e_win;
      h_err  <= h_win & h_ro;
      mem_en <= (h_win & ~h_ro) | e_win;
      mem_wr <= h_win & h_wr & ~h_ro;
      if (h_win) begin
        mem_addr  <= h_addr;
        mem_wdata <= h_wdata;
      end else if (e_win) begin
        mem_addr  <= e_addr;
      end
      if (h_win || e_win) last_host <= h_win;
    end
  end

  // Owner tag follows each read command so the returning word reaches its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_host  <= 1'b0;
      h_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      h_rdata  <= '0;
      e_rdata  <= '0;
    end else begin
      rd_pend  <= mem_en & ~mem_wr;
      rd_host  <= h_gnt;
      h_rvalid <= rd_pend & rd_host;
      e_rvalid <= rd_pend & ~rd_host;
      if (rd_pend && rd_host)  h_rdata <= mem_rdata;
      if (rd_pend && !rd_host) e_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fir_regbus_arbiter.sv
// Bench for fir_regbus_arbiter: round-robin and host-priority instances driven side by side,
// each against a behavioural memory and a transaction-level reference model.
module tb_fir_regbus_arbiter;

  localparam int AW      = 6;
  localparam int DW      = 16;
  localparam int RO_BASE = 48;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          h_req     [2];
  logic          h_wr      [2];
  logic [AW-1:0] h_addr    [2];
  logic [DW-1:0] h_wdata   [2];
  logic          h_gnt     [2];
  logic          h_rvalid  [2];
  logic [DW-1:0] h_rdata   [2];
  logic          h_err     [2];
  logic          e_req     [2];
  logic [AW-1:0] e_addr    [2];
  logic          e_gnt     [2];
  logic          e_rvalid  [2];
  logic [DW-1:0] e_rdata   [2];
  logic          mem_en    [2];
  logic          mem_wr    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  fir_regbus_arbiter #(.AW(AW), .DW(DW), .RO_BASE(RO_BASE), .HOST_PRIO(0)) u_rr (
    .clk(clk), .rst(rst[0]),
    .h_req(h_req[0]), .h_wr(h_wr[0]), .h_addr(h_addr[0]), .h_wdata(h_wdata[0]),
    .h_gnt(h_gnt[0]), .h_rvalid(h_rvalid[0]), .h_rdata(h_rdata[0]), .h_err(h_err[0]),
    .e_req(e_req[0]), .e_addr(e_addr[0]), .e_gnt(e_gnt[0]), .e_rvalid(e_rvalid[0]),
    .e_rdata(e_rdata[0]), .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  fir_regbus_arbiter #(.AW(AW), .DW(DW), .RO_BASE(RO_BASE), .HOST_PRIO(1)) u_prio (
    .clk(clk), .rst(rst[1]),
    .h_req(h_req[1]), .h_wr(h_wr[1]), .h_addr(h_addr[1]), .h_wdata(h_wdata[1]),
    .h_gnt(h_gnt[1]), .h_rvalid(h_rvalid[1]), .h_rdata(h_rdata[1]), .h_err(h_err[1]),
    .e_req(e_req[1]), .e_addr(e_addr[1]), .e_gnt(e_gnt[1]), .e_rvalid(e_rvalid[1]),
    .e_rdata(e_rdata[1]), .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Reference memory contents and the queued requester operations shared by both instances.
  logic [DW-1:0] ref_mem [2][64];
  logic [DW-1:0] dev_mem [2][64];
  op_t           h_ops[$];
  op_t           e_ops[$];
  int            h_idx [2];
  int            e_idx [2];

  // Expected outputs for the cycle currently visible.
  bit            ex_h_gnt [2];
  bit            ex_e_gnt [2];
  bit            ex_h_err [2];
  bit            ex_en    [2];
  bit            ex_wr    [2];
  bit            ex_h_rv  [2];
  bit            ex_e_rv  [2];
  bit            ex_zero  [2];
  logic [AW-1:0] ex_addr  [2];
  logic [DW-1:0] ex_wdata [2];
  logic [DW-1:0] ex_h_rd  [2];
  logic [DW-1:0] ex_e_rd  [2];

  bit            last_host [2];
  bit            ret_v [2][4];
  bit            ret_h [2][4];
  logic [DW-1:0] ret_d [2][4];
  int            rst_cnt [2];
  bit            arm_rst [2];
  bit            rand_mode;
  int            cyc;
  int            checks;
  int            errors;

  // Simple synchronous memory: one-cycle read latency, preloaded from the reference on the first edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cyc == 0) begin
        for (int a = 0; a < 64; a++) dev_mem[k][a] <= ref_mem[k][a];
      end else if (mem_en[k]) begin
        if (mem_wr[k]) dev_mem[k][mem_addr[k]] <= mem_wdata[k];
        else           mem_rdata[k] <= dev_mem[k][mem_addr[k]];
      end
    end
  end

  task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d got %0h expected %0h", tag, k, cyc, got, exp);
    end
  endtask

  function automatic op_t mk(input bit wr, input int addr, input int data);
    op_t o;
    o.wr   = wr;
    o.addr = addr[AW-1:0];
    o.data = data[DW-1:0];
    return o;
  endfunction

  task automatic compare(input int k);
    check("h_gnt",    k, 32'(h_gnt[k]),    32'(ex_h_gnt[k]));
    check("e_gnt",    k, 32'(e_gnt[k]),    32'(ex_e_gnt[k]));
    check("h_err",    k, 32'(h_err[k]),    32'(ex_h_err[k]));
    check("mem_en",   k, 32'(mem_en[k]),   32'(ex_en[k]));
    check("mem_wr",   k, 32'(mem_wr[k]),   32'(ex_wr[k]));
    check("h_rvalid", k, 32'(h_rvalid[k]), 32'(ex_h_rv[k]));
    check("e_rvalid", k, 32'(e_rvalid[k]), 32'(ex_e_rv[k]));
    check("h_rdata",  k, 32'(h_rdata[k]),  32'(ex_h_rd[k]));
    check("e_rdata",  k, 32'(e_rdata[k]),  32'(ex_e_rd[k]));
    if (ex_en[k] || ex_zero[k]) check("mem_addr",  k, 32'(mem_addr[k]),  32'(ex_addr[k]));
    if (ex_wr[k] || ex_zero[k]) check("mem_wdata", k, 32'(mem_wdata[k]), 32'(ex_wdata[k]));
  endtask

  // Drive one cycle of inputs for instance k and predict its outputs for the following cycle.
  task automatic step(input int k);
    op_t op;
    bit  h_el, e_el, hw, ew;
    int  now_s, due_s;

    if (rand_mode && h_idx[k] < h_ops.size() && $urandom_range(0, 299) == 0)
      rst_cnt[k] = int'($urandom_range(1, 2));
    rst[k] = (rst_cnt[k] > 0);
    if (rst_cnt[k] > 0) rst_cnt[k]--;
    if (arm_rst[k] && ex_e_gnt[k]) begin
      rst_cnt[k] = 1;
      arm_rst[k] = 1'b0;
    end

    if (h_req[k] && ex_h_gnt[k]) h_req[k] = 1'b0;
    if (!h_req[k] && h_idx[k] < h_ops.size() && (!rand_mode || $urandom_range(0, 1) == 1)) begin
      op = h_ops[h_idx[k]];
      h_idx[k]++;
      h_req[k] = 1'b1; h_wr[k] = op.wr; h_addr[k] = op.addr; h_wdata[k] = op.data;
    end
    if (e_req[k] && ex_e_gnt[k]) e_req[k] = 1'b0;
    if (!e_req[k] && e_idx[k] < e_ops.size() && (!rand_mode || $urandom_range(0, 1) == 1)) begin
      op = e_ops[e_idx[k]];
      e_idx[k]++;
      e_req[k] = 1'b1; e_addr[k] = op.addr;
    end

    h_el  = h_req[k] && !ex_h_gnt[k];
    e_el  = e_req[k] && !ex_e_gnt[k];
    now_s = (cyc + 1) % 4;
    due_s = (cyc + 3) % 4;

    if (rst[k]) begin
      ex_h_gnt[k] = 0; ex_e_gnt[k] = 0; ex_h_err[k] = 0; ex_en[k] = 0; ex_wr[k] = 0;
      ex_h_rv[k] = 0; ex_e_rv[k] = 0; ex_addr[k] = '0; ex_wdata[k] = '0;
      ex_h_rd[k] = '0; ex_e_rd[k] = '0; ex_zero[k] = 1;
      last_host[k] = 1;
      for (int s = 0; s < 4; s++) ret_v[k][s] = 0;
    end else begin
      ex_zero[k] = 0;
      // Host wins a conflict under priority mode, or when the engine was served last.
      hw = h_el && (!e_el || k == 1 || !last_host[k]);
      ew = e_el && !hw;
      ex_h_gnt[k] = hw; ex_e_gnt[k] = ew;
      ex_h_err[k] = 0; ex_en[k] = 0; ex_wr[k] = 0;
      if (hw) begin
        last_host[k] = 1;
        ex_addr[k]   = h_addr[k];
        ex_wdata[k]  = h_wdata[k];
        if (h_wr[k]) begin
          if (int'(h_addr[k]) >= RO_BASE) ex_h_err[k] = 1;
          else begin
            ex_en[k] = 1; ex_wr[k] = 1;
            ref_mem[k][h_addr[k]] = h_wdata[k];
          end
        end else begin
          ex_en[k] = 1;
          ret_v[k][due_s] = 1; ret_h[k][due_s] = 1; ret_d[k][due_s] = ref_mem[k][h_addr[k]];
        end
      end else if (ew) begin
        last_host[k] = 0;
        ex_addr[k]   = e_addr[k];
        ex_en[k]     = 1;
        ret_v[k][due_s] = 1; ret_h[k][due_s] = 0; ret_d[k][due_s] = ref_mem[k][e_addr[k]];
      end
      ex_h_rv[k] = ret_v[k][now_s] && ret_h[k][now_s];
      ex_e_rv[k] = ret_v[k][now_s] && !ret_h[k][now_s];
      if (ex_h_rv[k]) ex_h_rd[k] = ret_d[k][now_s];
      if (ex_e_rv[k]) ex_e_rd[k] = ret_d[k][now_s];
      ret_v[k][now_s] = 0;
    end
  endtask

  function automatic bit idle_all();
    bit busy = 0;
    for (int k = 0; k < 2; k++) begin
      if (h_idx[k] < h_ops.size() || e_idx[k] < e_ops.size()) busy = 1;
      if (h_req[k] || e_req[k] || rst_cnt[k] > 0 || ex_h_gnt[k] || ex_e_gnt[k]) busy = 1;
      for (int s = 0; s < 4; s++) if (ret_v[k][s]) busy = 1;
    end
    return !busy;
  endfunction

  task automatic run(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      for (int k = 0; k < 2; k++) step(k);
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) compare(k);
      if (idle_all()) quiet++;
      else            quiet = 0;
      n++;
    end
    if (quiet < 4) begin
      checks++;
      errors++;
      $display("FAIL drain: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    int            a;
    checks = 0; errors = 0; cyc = 0; rand_mode = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; h_req[k] = 0; h_wr[k] = 0; h_addr[k] = '0; h_wdata[k] = '0;
      e_req[k] = 0; e_addr[k] = '0;
      ex_h_gnt[k] = 0; ex_e_gnt[k] = 0; ex_h_err[k] = 0; ex_en[k] = 0; ex_wr[k] = 0;
      ex_h_rv[k] = 0; ex_e_rv[k] = 0; ex_zero[k] = 1; ex_addr[k] = '0; ex_wdata[k] = '0;
      ex_h_rd[k] = '0; ex_e_rd[k] = '0; last_host[k] = 1; rst_cnt[k] = 3; arm_rst[k] = 0;
      h_idx[k] = 0; e_idx[k] = 0;
      for (int s = 0; s < 4; s++) begin
        ret_v[k][s] = 0; ret_h[k][s] = 0; ret_d[k][s] = '0;
      end
    end
    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom);
      ref_mem[0][i] = v;
      ref_mem[1][i] = v;
    end
    for (int k = 0; k < 2; k++) begin
      ref_mem[k][1]  = 16'h1111; ref_mem[k][10] = 16'h1234;
      ref_mem[k][32] = 16'hDEAD; ref_mem[k][63] = 16'hBEEF;
      ref_mem[k][48] = 16'h4848;
    end

    // Reset held with both requests pending; engine takes the first conflict.
    h_ops.push_back(mk(0, 1, 0));
    e_ops.push_back(mk(0, 32, 0));
    run(200);

    // Host write then readback of the same address.
    h_ops.push_back(mk(1, 5, 16'hABCD));
    h_ops.push_back(mk(0, 5, 0));
    run(200);
    for (int k = 0; k < 2; k++) check("mem5", k, 32'(dev_mem[k][5]), 32'h0000ABCD);

    // Continuous contention: host alternates 1/10, engine alternates 32/63.
    for (int i = 0; i < 4; i++) begin
      h_ops.push_back(mk(0, 1, 0));  h_ops.push_back(mk(0, 10, 0));
      e_ops.push_back(mk(0, 32, 0)); e_ops.push_back(mk(0, 63, 0));
    end
    run(300);

    // Read-only boundary: 48 is dropped, 47 is written.
    h_ops.push_back(mk(1, 48, 16'hBEEF));
    h_ops.push_back(mk(1, 47, 16'h1357));
    h_ops.push_back(mk(0, 48, 0));
    h_ops.push_back(mk(0, 47, 0));
    run(200);
    for (int k = 0; k < 2; k++) begin
      check("mem48", k, 32'(dev_mem[k][48]), 32'h00004848);
      check("mem47", k, 32'(dev_mem[k][47]), 32'h00001357);
    end

    // Reset lands in the cycle after an engine read grant; that read must never return.
    arm_rst[0] = 1; arm_rst[1] = 1;
    e_ops.push_back(mk(0, 32, 0));
    e_ops.push_back(mk(0, 63, 0));
    run(200);

    // Randomised traffic with gaps, boundary-biased addresses and occasional resets.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 46 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      h_ops.push_back(mk($urandom_range(0, 1) == 1, a, int'($urandom)));
      e_ops.push_back(mk(0, int'($urandom_range(0, 63)), 0));
    end
    rand_mode = 1;
    run(20000);
    rand_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
